// File: rtl/cordic_engine.sv
// Iterative CORDIC engine (rotation/vectoring) with valid/ready handshakes, one micro-rotation per cycle.
// Optional gain compensation stage enabled by defining CORDIC_GAIN_COMP_EN.
module cordic_engine #(
    parameter int N_FRAC     = 7,
    parameter int ITERATIONS = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic                     mode_i,
    input  logic signed [N_FRAC:0]   x_i,
    input  logic signed [N_FRAC:0]   y_i,
    input  logic signed [N_FRAC:0]   z_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic signed [N_FRAC:0]   x_o,
    output logic signed [N_FRAC:0]   y_o,
    output logic signed [N_FRAC:0]   z_o,
    output logic                     busy_o
);

    localparam int  W  = N_FRAC + 1;
    localparam int  IW = N_FRAC + 3;
    localparam int  CW = $clog2(ITERATIONS + 1);
    localparam real PI = 3.14159265358979323846;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_OUTPUT = 2'd2
`ifdef CORDIC_GAIN_COMP_EN
        , S_COMP = 2'd3
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          iter_q, iter_d;
    logic                   mode_q, mode_d;
    logic signed [IW-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [W-1:0]    xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;

    // round(atan(2^-i)/pi * 2^N_FRAC), evaluated at elaboration only
    function automatic int atan_lut(input int i);
        real r;
        r = $atan(1.0 / (2.0 ** i)) / PI * (2.0 ** N_FRAC);
        return $rtoi(r + 0.5);
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [IW-1:0] v);
        if ((v[IW-1:W-1] == '0) || (v[IW-1:W-1] == '1))
            return v[W-1:0];
        else if (v[IW-1])
            return {1'b1, {N_FRAC{1'b0}}};
        else
            return {1'b0, {N_FRAC{1'b1}}};
    endfunction

`ifdef CORDIC_GAIN_COMP_EN
    // 1/K ~= 0.607 as x/2 + x/8 - x/64 - x/512
    function automatic logic signed [IW-1:0] gain_comp(input logic signed [IW-1:0] v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
    endfunction
`endif

    // Table padded to 2^CW entries so the counter can index it directly
    logic signed [IW-1:0] atan_tab [2**CW];
    for (genvar g = 0; g < 2**CW; g++) begin : g_atan
        localparam int A = (g < ITERATIONS) ? atan_lut(g) : 0;
        assign atan_tab[g] = IW'(A);
    end

    logic                 d_pos;
    logic signed [IW-1:0] x_sh, y_sh, atan_cur, x_rot, y_rot, z_rot;

    always_comb begin
        x_sh     = x_q >>> iter_q;
        y_sh     = y_q >>> iter_q;
        atan_cur = atan_tab[iter_q];
        d_pos    = mode_q ? y_q[IW-1] : ~z_q[IW-1];
        x_rot    = d_pos ? (x_q - y_sh) : (x_q + y_sh);
        y_rot    = d_pos ? (y_q + x_sh) : (y_q - x_sh);
        z_rot    = d_pos ? (z_q - atan_cur) : (z_q + atan_cur);
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        zo_d    = zo_q;
        case (state_q)
            S_IDLE: begin
                if (s_valid_i) begin
                    state_d = S_CALC;
                    iter_d  = '0;
                    mode_d  = mode_i;
                    x_d     = {{2{x_i[W-1]}}, x_i};
                    y_d     = {{2{y_i[W-1]}}, y_i};
                    z_d     = {{2{z_i[W-1]}}, z_i};
                end
            end
            S_CALC: begin
                // Counter runs one step past the last micro-rotation; that step
                // registers the (saturated) result so latency is ITERATIONS+1.
                if (iter_q == CW'(ITERATIONS)) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = S_COMP;
`else
                    xo_d    = sat(x_q);
                    yo_d    = sat(y_q);
                    zo_d    = z_q[W-1:0];
                    state_d = S_OUTPUT;
`endif
                end else begin
                    x_d    = x_rot;
                    y_d    = y_rot;
                    z_d    = z_rot;
                    iter_d = iter_q + CW'(1);
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            S_COMP: begin
                xo_d    = sat(gain_comp(x_q));
                yo_d    = sat(gain_comp(y_q));
                zo_d    = z_q[W-1:0];
                state_d = S_OUTPUT;
            end
`endif
            S_OUTPUT: begin
                if (m_ready_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            mode_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            zo_q    <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            zo_q    <= zo_d;
        end
    end

    assign s_ready_o = (state_q == S_IDLE);
    assign m_valid_o = (state_q == S_OUTPUT);
    assign busy_o    = (state_q != S_IDLE);
    assign x_o       = xo_q;
    assign y_o       = yo_q;
    assign z_o       = zo_q;

endmodule

// File: tb/tb_cordic_engine.sv
// Scoreboard bench for cordic_engine: directed vectors with hand-computed results, N_FRAC=7, ITERATIONS=6.
module tb_cordic_engine;

    localparam int N_FRAC     = 7;
    localparam int ITERATIONS = 6;
    localparam int W          = N_FRAC + 1;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int COMP = 1;
`else
    localparam int COMP = 0;
`endif
    localparam int LAT     = ITERATIONS + 1 + COMP;
    localparam int SPACING = ITERATIONS + 3 + COMP;

    logic                clk = 1'b0;
    logic                rst_i, s_valid_i, mode_i, m_ready_i;
    logic                s_ready_o, m_valid_o, busy_o;
    logic signed [W-1:0] x_i, y_i, z_i, x_o, y_o, z_o;

    cordic_engine #(.N_FRAC(N_FRAC), .ITERATIONS(ITERATIONS)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .mode_i(mode_i),
        .x_i(x_i), .y_i(y_i), .z_i(z_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .x_o(x_o), .y_o(y_o), .z_o(z_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    x, y, z;
        int    acc;
        string name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;
    int   nres     = 0;
    logic mv_prev  = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: latency on the rising edge of m_valid_o, data on each handshake
    always @(negedge clk) begin
        if (rst_i) begin
            mv_prev <= 1'b0;
        end else begin
            if (m_valid_o && !mv_prev) begin
                if (q.size() == 0)
                    check("unexpected_result", 1, 0);
                else
                    check({q[0].name, "_latency"}, cyc - q[0].acc, LAT);
            end
            if (m_valid_o && m_ready_i && q.size() != 0) begin
                e = q.pop_front();
                nres++;
                check({e.name, "_x"}, x_o, e.x);
                check({e.name, "_y"}, y_o, e.y);
                check({e.name, "_z"}, z_o, e.z);
            end
            mv_prev <= m_valid_o;
        end
    end

    task automatic send(input string name, input logic md, input int xi, input int yi, input int zi,
                        input int ex, input int ey, input int ez, input bit push, input bit hold,
                        output int acc);
        exp_t t;
        int   n;
        mode_i    = md;
        x_i       = W'(xi);
        y_i       = W'(yi);
        z_i       = W'(zi);
        s_valid_i = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_ready_o) break;
            n++;
            if (n > 100) begin
                check({name, "_accept_timeout"}, 0, 1);
                s_valid_i = 1'b0;
                acc = -1;
                return;
            end
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (push) begin
            t.x = ex; t.y = ey; t.z = ez; t.acc = acc; t.name = name;
            q.push_back(t);
        end
        if (!hold) s_valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) check({name, "_drain_timeout"}, int'(q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int a1, a2, a3, n0, n;
        int rx, ry, vx, vy, bx, by, r0x, r0y;
        if (COMP != 0) begin
            rx = 45; ry = 45; vx = 91; vy = 0; bx = -128; by = 1; r0x = 65; r0y = 0;
        end else begin
            rx = 74; ry = 75; vx = 127; vy = -1; bx = -128; by = 3; r0x = 106; r0y = -2;
        end

        rst_i = 1'b1; s_valid_i = 1'b0; mode_i = 1'b0; m_ready_i = 1'b1;
        x_i = '0; y_i = '0; z_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        check("rst_m_valid", m_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_s_ready", s_ready_o, 1);
        check("rst_x_o", x_o, 0);

        // Directed vectors: rotation, vectoring, boundary operands
        send("rot45",   1'b0,   64,    0,  32, rx,  ry,    0, 1'b1, 1'b0, a1); drain("rot45");
        send("vec45",   1'b1,   64,   64,   0, vx,  vy,   32, 1'b1, 1'b0, a1); drain("vec45");
        send("bnd_rot", 1'b0, -128,    0,   0, bx,  by,    0, 1'b1, 1'b0, a1); drain("bnd_rot");
        send("bnd_vec", 1'b1,  127, -128,   0, 127,  0,  -32, 1'b1, 1'b0, a1); drain("bnd_vec");

        // Backpressure: hold the result for 5 cycles
        m_ready_i = 1'b0;
        send("bp", 1'b0, 64, 0, 32, rx, ry, 0, 1'b1, 1'b0, a1);
        n = 0;
        while (!m_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", m_valid_o, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_m_valid_hold", m_valid_o, 1);
            check("bp_s_ready_low", s_ready_o, 0);
            check("bp_x_stable", x_o, rx);
            check("bp_y_stable", y_o, ry);
        end
        @(posedge clk);
        #1;
        m_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("bp_m_valid_drop", m_valid_o, 0);
        check("bp_s_ready_back", s_ready_o, 1);
        drain("bp");

        // Back-to-back with s_valid_i held high
        n0 = nres;
        send("b2b_a", 1'b0, 64,  0,  32, rx,  ry,  0, 1'b1, 1'b1, a1);
        send("b2b_b", 1'b0, 64,  0,   0, r0x, r0y, 0, 1'b1, 1'b1, a2);
        send("b2b_c", 1'b0,  0, 64, -32, rx,  ry,  0, 1'b1, 1'b0, a3);
        check("b2b_spacing_ab", a2 - a1, SPACING);
        check("b2b_spacing_bc", a3 - a2, SPACING);
        drain("b2b");
        repeat (20) @(posedge clk);
        #1;
        check("b2b_result_count", nres - n0, 3);
        check("b2b_idle_after", busy_o, 0);

        // Reset mid-CALC discards the operation
        send("rst_mid", 1'b0, 64, 0, 32, 0, 0, 0, 1'b0, 1'b0, a1);
        repeat (3) @(posedge clk);
        #1;
        check("calc_busy", busy_o, 1);
        check("calc_s_ready", s_ready_o, 0);
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        check("midrst_m_valid", m_valid_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_s_ready", s_ready_o, 1);
        check("midrst_x_o", x_o, 0);
        check("midrst_y_o", y_o, 0);
        check("midrst_z_o", z_o, 0);
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_stale", m_valid_o, 0);

        // Engine still usable after the aborted operation
        send("post_rst", 1'b1, 64, 64, 0, vx, vy, 32, 1'b1, 1'b0, a1);
        drain("post_rst");
        check("queue_empty", int'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
